// File: rtl/macram_sched_if.sv
// Bank-side port of the MAC RAM scheduler: strobes and read address out, read data back.
interface macram_sched_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              mac_sin;
  logic              mac_clr;
  logic              mac_read;
  logic [ADDR_W-1:0] mac_raddr;
  logic [DATA_W-1:0] mac_rdata;

  modport master (output mac_sin, mac_clr, mac_read, mac_raddr, input mac_rdata);
  modport slave  (input mac_sin, mac_clr, mac_read, mac_raddr, output mac_rdata);
endinterface

// File: rtl/macram_sched.sv
// Scheduler for a MAC RAM bank: sample sweeps, clears and full readouts with pending-request queuing.
// Optional MACRAM_SCHED_OVF_CNT_EN adds a saturating dropped-sample counter (ovf_cnt).
module macram_sched #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              samp_req,
  input  logic              clr_req,
  input  logic              dump_req,
  macram_sched_if.master    bank,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              busy,
`ifdef MACRAM_SCHED_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  output logic              overrun
);
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_CLR, S_DUMP, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t                       r_state, w_state_nxt;
  logic [ADDR_W-1:0]            r_cnt, w_cnt_nxt;
  logic                         r_samp_pend, r_clr_pend, r_dump_pend;
  logic                         r_overrun;
  logic [1:0]                   r_vld_pipe;
  logic [1:0][ADDR_W-1:0]       r_addr_pipe;
  logic                         w_idle, w_clr_go, w_samp_go, w_dump_go, w_drop;

  // Issue decisions are combinational so an idle strobe goes out in its own cycle.
  always_comb begin
    w_idle    = (r_state == S_IDLE) && !rst;
    w_clr_go  = w_idle && (r_clr_pend || clr_req);
    w_samp_go = w_idle && !w_clr_go && (r_samp_pend || samp_req);
    w_dump_go = w_idle && !w_clr_go && !w_samp_go && (r_dump_pend || dump_req);
    w_drop    = samp_req && r_samp_pend && !w_samp_go;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_clr_go)       w_state_nxt = S_CLR;
        else if (w_samp_go) w_state_nxt = S_MAC;
        else if (w_dump_go) w_state_nxt = S_DUMP;
      end
      S_MAC, S_CLR: begin
        w_cnt_nxt = r_cnt + ONE;
        if (r_cnt == LAST) w_state_nxt = S_IDLE;
      end
      S_DUMP: begin
        w_cnt_nxt = r_cnt + ONE;
        if (r_cnt == LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_cnt_nxt = r_cnt + ONE;
        if (r_cnt == ONE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bank.mac_sin   = w_samp_go;
    bank.mac_clr   = w_clr_go;
    bank.mac_read  = w_dump_go || (r_state == S_DUMP);
    bank.mac_raddr = (r_state == S_DUMP) ? r_cnt : '0;
    busy           = (r_state != S_IDLE) || w_clr_go || w_samp_go || w_dump_go;
    overrun        = r_overrun;
    dump_valid     = r_vld_pipe[1];
    dump_addr      = r_vld_pipe[1] ? r_addr_pipe[1] : '0;
    dump_data      = r_vld_pipe[1] ? bank.mac_rdata : '0;
    dump_last      = r_vld_pipe[1] && (r_addr_pipe[1] == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_samp_pend <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_dump_pend <= 1'b0;
      r_overrun   <= 1'b0;
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // A strobe coinciding with consumption of a set flag re-arms it.
      r_samp_pend <= w_samp_go ? (samp_req && r_samp_pend) : (r_samp_pend || samp_req);
      r_clr_pend  <= w_clr_go  ? 1'b0 : (r_clr_pend  || clr_req);
      r_dump_pend <= w_dump_go ? 1'b0 : (r_dump_pend || dump_req);
      r_overrun   <= r_overrun || w_drop;
      // Bank read data lags the address by two cycles.
      r_vld_pipe  <= {r_vld_pipe[0], r_state == S_DUMP};
      r_addr_pipe <= {r_addr_pipe[0], bank.mac_raddr};
    end
  end

`ifdef MACRAM_SCHED_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  always_ff @(posedge clk) begin
    if (rst)                               r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != '1)    r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end
  assign ovf_cnt = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_macram_sched.sv
// Randomized scoreboard bench for macram_sched: a time-based schedule model predicts bank strobes and dump beats.
module tb_macram_sched;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
  localparam int R  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic samp_req = 1'b0, clr_req = 1'b0, dump_req = 1'b0;
  logic dump_valid, dump_last, busy, overrun;
  logic [DW-1:0] dump_data;
  logic [AW-1:0] dump_addr;
`ifdef MACRAM_SCHED_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  macram_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  macram_sched #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .samp_req(samp_req), .clr_req(clr_req), .dump_req(dump_req),
    .bank(bif), .dump_valid(dump_valid), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .busy(busy),
`ifdef MACRAM_SCHED_OVF_CNT_EN
    .ovf_cnt(ovf_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Bank stand-in: two-cycle registered read.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= ram[bif.mac_raddr];
    rd2 <= rd1;
  end
  assign bif.mac_rdata = rd2;

  typedef struct {int cyc; int kind; int addr; logic [DW-1:0] data; bit last;} ev_t;
  ev_t q[$];

  int checks = 0, errors = 0;
  int cyc_now = 0;
  bit armed = 0;
  bit e_busy[R], e_read[R], e_ovr[R];
  int e_raddr[R];

  // Reference state: next idle cycle, pending flags, overrun tally.
  int m_free = 0;
  bit m_sf = 0, m_cf = 0, m_df = 0, m_ovr = 0;
  int m_ovf = 0;

  always @(posedge clk) cyc_now = cyc_now + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc_now, act, exp);
    end
  endtask

  task automatic samp_arrival(bit s);
    if (s) begin
      if (m_sf) begin m_ovr = 1; m_ovf++; end
      else m_sf = 1;
    end
  endtask

  task automatic model(int c, bit s, bit cl, bit d, bit r);
    bit busy_now = (c < m_free);
    bit issued = 0;
    e_ovr[c % R] = m_ovr;
    if (r) begin
      e_busy[c % R] = busy_now;
      for (int k = 1; k <= N + 3; k++) begin
        e_read[(c + k) % R] = 0;
        e_raddr[(c + k) % R] = 0;
      end
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc > c) q.delete(i);
      m_sf = 0; m_cf = 0; m_df = 0; m_ovr = 0; m_ovf = 0;
      m_free = c + 1;
      return;
    end
    if (!busy_now && (m_cf || cl)) begin
      issued = 1; m_cf = 0; m_df = m_df | d; m_free = c + N + 1;
      q.push_back('{c, 1, 0, '0, 0});
      samp_arrival(s);
    end else if (!busy_now && (m_sf || s)) begin
      issued = 1; m_sf = m_sf & s; m_df = m_df | d; m_free = c + N + 1;
      q.push_back('{c, 0, 0, '0, 0});
    end else if (!busy_now && (m_df || d)) begin
      issued = 1; m_df = 0; m_free = c + N + 3;
      for (int i = 0; i <= N; i++) e_read[(c + i) % R] = 1;
      for (int i = 0; i < N; i++) e_raddr[(c + 1 + i) % R] = i;
      q.push_back('{c, 2, 0, '0, 0});
      for (int i = 0; i < N; i++) q.push_back('{c + 3 + i, 3, i, ram[i], i == N - 1});
      samp_arrival(s);
    end else begin
      m_cf = m_cf | cl; m_df = m_df | d;
      samp_arrival(s);
    end
    e_busy[c % R] = busy_now || issued;
  endtask

  task automatic step(bit s, bit cl, bit d, bit r);
    @(posedge clk); #1;
    samp_req = s; clr_req = cl; dump_req = d; rst = r;
    armed = 1;
    model(cyc_now, s, cl, d, r);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic obs(int kind, int addr, logic [DW-1:0] data, bit last);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", 64'(kind), 64'hFF);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", 64'(kind), 64'(e.kind));
    chk("ev_cycle", 64'(cyc_now), 64'(e.cyc));
    if (kind == 3 && e.kind == 3) begin
      chk("dump_addr", 64'(addr), 64'(e.addr));
      chk("dump_data", 64'(data), 64'(e.data));
      chk("dump_last", 64'(last), 64'(e.last));
    end
  endtask

  bit prev_read = 0;
  always @(negedge clk) begin : mon
    int k;
    if (armed) begin
      k = cyc_now % R;
      chk("busy", 64'(busy), 64'(e_busy[k]));
      chk("mac_read", 64'(bif.mac_read), 64'(e_read[k]));
      chk("mac_raddr", 64'(bif.mac_raddr), 64'(e_raddr[k]));
      chk("overrun", 64'(overrun), 64'(e_ovr[k]));
      if (32'(bif.mac_sin) + 32'(bif.mac_clr) + 32'(bif.mac_read) > 1)
        chk("strobe_excl", {61'd0, bif.mac_sin, bif.mac_clr, bif.mac_read}, 64'd0);
      if (bif.mac_sin) obs(0, 0, '0, 0);
      if (bif.mac_clr) obs(1, 0, '0, 0);
      if (bif.mac_read && !prev_read) obs(2, 0, '0, 0);
      if (dump_valid) obs(3, int'(dump_addr), dump_data, dump_last);
      else chk("dump_idle", 64'({dump_addr, dump_data, dump_last}), 64'd0);
      prev_read = bif.mac_read;
      e_read[k] = 0;
      e_raddr[k] = 0;
    end
  end

  task automatic chk_zero(string nm);
    @(negedge clk); #1;
    chk(nm, 64'({bif.mac_sin, bif.mac_clr, bif.mac_read, bif.mac_raddr, dump_valid,
                 dump_addr, dump_last, busy, overrun}), 64'd0);
    chk({nm, "_data"}, 64'(dump_data), 64'd0);
  endtask

  initial begin
    for (int a = 0; a < N; a++) ram[a] = DW'(a + 100);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk_zero("reset_state");
    idle(5);
    step(1, 0, 0, 0); idle(40);              // lone sample
    step(1, 1, 0, 0); idle(75);              // clear beats sample
    step(0, 0, 1, 0); idle(40);              // dump of preloaded bank
    step(1, 0, 0, 0); idle(4); step(1, 0, 0, 0); idle(3); step(1, 0, 0, 0); idle(70);
    step(0, 1, 1, 0); step(0, 0, 1, 0); step(0, 1, 0, 0); idle(110);
    for (int a = 0; a < N; a++) ram[a] = $urandom;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 599) == 0);
    step(0, 0, 0, 1); idle(3);
    step(0, 0, 1, 0); idle(14);
    step(0, 0, 0, 1);                        // abort dump mid-flight
    step(0, 0, 0, 0);
    chk_zero("abort_state");
    idle(3); step(1, 0, 0, 0); idle(40);
`ifdef MACRAM_SCHED_OVF_CNT_EN
    for (int i = 0; i < 67600; i++) step(1, 0, 0, 0);
    @(negedge clk); #1;
    chk("ovf_cnt_sat", 64'(ovf_cnt), 64'(m_ovf > 65535 ? 65535 : m_ovf));
    chk("ovf_dropped_enough", 64'(m_ovf >= 65540), 64'd1);
`endif
    idle(80);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
